rat_alu_pipe: RTL and testbench
===============================

// Module: rat_alu_pipe
// PURPOSE
//  Parametrised, registered successor to the RAT ALU.
//  - Accepts one operation per valid/ready handshake and returns RESULT/C/Z through a one-deep output register.
//  - Holds architectural C/Z flags internally; ADDC/SUBC take their carry from those flags.
//  - Sits between the RAT control unit/register file and the register-file write port.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 4..32
// PORTS
//  CLK        in   1      clock; all state changes on rising edge
//  RST_N      in   1      asynchronous, active-low reset
//  IN_VALID   in   1      SEL/A/B are valid this cycle
//  IN_READY   out  1      block can accept an operation this cycle
//  SEL        in   4      opcode, encoded as listed under BEHAVIOUR
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  OUT_VALID  out  1      RESULT/C/Z/RES_WE hold a completed operation
//  OUT_READY  in   1      consumer takes the result this cycle
//  RESULT     out  WIDTH  operation result
//  C          out  1      carry/borrow produced by this operation
//  Z          out  1      1 when RESULT == 0
//  RES_WE     out  1      result is to be written back; 0 for CMP and TEST
//  FLAG_C     out  1      architectural carry flag
//  FLAG_Z     out  1      architectural zero flag
// BEHAVIOUR
//  Reset (RST_N=0, takes effect immediately): state=IDLE, OUT_VALID=0, RESULT=0, C=0, Z=0, RES_WE=0,
//   FLAG_C=0, FLAG_Z=0. Any in-flight operation is discarded. IN_READY=1 from the first edge after release.
//  Acceptance: an operation is accepted on the edge where IN_VALID && IN_READY.
//   IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY), so a single-cycle op can issue back-to-back
//   while the previous result drains.
//  Arithmetic: performed at WIDTH+1 bits; C = bit WIDTH of the sum/difference; CF = FLAG_C.
//  SEL 0 ADD  A+B              SEL 1 ADDC A+B+CF             SEL 2 SUB A-B (C=borrow)
//  SEL 3 SUBC A-B-CF           SEL 4 CMP  as SUB, RES_WE=0   SEL 5 AND, C=0
//  SEL 6 OR,  C=0              SEL 7 XOR, C=0                SEL 8 TEST as AND, RES_WE=0
//  SEL 9  LSL  {C,R}={A,CF}
//  SEL 10 LSR  C=A[0], R={CF,A[W-1:1]}
//  SEL 11 ROL  C=A[W-1], R={A[W-2:0],A[W-1]}
//  SEL 12 ROR  C=A[0],   R={A[0],A[W-1:1]}
//  SEL 13 ASR  C=A[0],   R={A[W-1],A[W-1:1]}
//  SEL 14 MOV  R=B, C=0
//  SEL 15 MUL (see CONFIGURATION)
//  Z = (R==0) for every op.
//  Latency: single-cycle ops give OUT_VALID=1 on the edge after acceptance.
//  Output hold: while OUT_VALID && !OUT_READY, the output registers hold their values exactly.
//   OUT_VALID drops after a handshake unless a new op is accepted on the same edge.
//  Flags: FLAG_C/FLAG_Z load C/Z on the output handshake edge (OUT_VALID && OUT_READY), for every op except
//   MOV, which leaves the flags unchanged.
//  Carry use: an ADDC/SUBC/LSL/LSR accepted on the same edge as the previous handshake uses the flag
//   value being written on that edge (bypass), never the stale one.
//  FSM states: IDLE, BUSY (MUL only).
//   IDLE->BUSY when a MUL is accepted; BUSY->IDLE when the cycle counter reaches WIDTH and the result loads.
//   IN_READY=0 throughout BUSY.
// CONFIGURATION
//  Macro RAT_ALU_MUL_EN.
//  Defined:
//   - SEL 15 is an unsigned shift-add multiply, WIDTH cycles in BUSY.
//   - OUT_VALID rises WIDTH+1 edges after acceptance.
//   - R = product[W-1:0]; C = |product[2W-1:W]; RES_WE=1.
//  Undefined:
//   - SEL 15 is single-cycle: R=0, C=0, Z=1, RES_WE=0.
//   - The BUSY state and multiply datapath are absent.
// TESTING
//  1. WIDTH=8: ADD A=8'hFF,B=8'h01, OUT_READY=1 -> next edge RESULT=00,C=1,Z=1; FLAG_C=1,FLAG_Z=1 after handshake.
//  2. FLAG_C=1, ADDC A=05,B=03 -> RESULT=09,C=0; SUB A=03,B=05 -> RESULT=FE,C=1,Z=0.
//  3. CMP A=42,B=42 -> RES_WE=0,Z=1,FLAG_Z=1; then MOV B=00 -> Z=1,RES_WE=1, flags unchanged.
//  4. Hold OUT_READY=0 for 5 cycles with IN_VALID=1 -> IN_READY=0, RESULT stable.
//     Release -> back-to-back ops stream one result per cycle.
//  5. RAT_ALU_MUL_EN, WIDTH=8: MUL A=10,B=20 -> OUT_VALID after 9 edges, RESULT=00,C=1,Z=1.
//     Assert RST_N=0 mid-BUSY -> all outputs 0, IN_READY=1 after release.
//  6. Shifts, A=8'h81, FLAG_C=0: LSL->02/C1; LSR->40/C1; ROL->03/C1; ROR->C0/C1; ASR->C0/C1.

Source files
------------

// File: rtl/rat_alu_pipe.sv
// Registered RAT ALU with valid/ready handshakes and internal C/Z flags.
// Define RAT_ALU_MUL_EN to make SEL 15 a multi-cycle shift-add multiply.
module rat_alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       SEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             C,
    output logic             Z,
    output logic             RES_WE,
    output logic             FLAG_C,
    output logic             FLAG_Z
);

    logic             r_live;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_c;
    logic             r_z;
    logic             r_we;
    logic             r_mov;
    logic             r_flag_c;
    logic             r_flag_z;

    logic             w_idle;
    logic             w_hs;
    logic             w_accept;
    logic             w_cf;
    logic             w_acc_mul;
    logic             w_done;
    logic [WIDTH-1:0] w_mul_res;
    logic             w_mul_c;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_we;
    logic             w_mov;

    assign w_hs     = r_out_valid && OUT_READY;
    assign IN_READY = r_live && w_idle && (!r_out_valid || OUT_READY);
    assign w_accept = IN_VALID && IN_READY;
    // Carry bypass: use the flag value being written on this very edge.
    assign w_cf     = (w_hs && !r_mov) ? r_c : r_flag_c;

`ifdef RAT_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    assign w_idle    = (r_state == S_IDLE);
    assign w_acc_mul = w_accept && (SEL == 4'd15);
    assign w_done    = (r_state == S_BUSY) && (r_cnt == CW'(WIDTH));
    assign w_mul_res = r_acc[WIDTH-1:0];
    assign w_mul_c   = |r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_acc_mul) w_next = S_BUSY;
            S_BUSY: if (w_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_acc_mul) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
        end else if (r_state == S_BUSY && !w_done) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end
`else
    assign w_idle    = 1'b1;
    assign w_acc_mul = 1'b0;
    assign w_done    = 1'b0;
    assign w_mul_res = '0;
    assign w_mul_c   = 1'b0;
`endif

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_we  = 1'b1;
        w_mov = 1'b0;
        case (SEL)
            4'd0: {w_c, w_res} = {1'b0, A} + {1'b0, B};
            4'd1: {w_c, w_res} = {1'b0, A} + {1'b0, B}
                               + (WIDTH+1)'(w_cf);
            4'd2: {w_c, w_res} = {1'b0, A} - {1'b0, B};
            4'd3: {w_c, w_res} = {1'b0, A} - {1'b0, B}
                               - (WIDTH+1)'(w_cf);
            4'd4: begin
                {w_c, w_res} = {1'b0, A} - {1'b0, B};
                w_we = 1'b0;
            end
            4'd5: w_res = A & B;
            4'd6: w_res = A | B;
            4'd7: w_res = A ^ B;
            4'd8: begin
                w_res = A & B;
                w_we  = 1'b0;
            end
            4'd9: {w_c, w_res} = {A, w_cf};
            4'd10: begin
                w_c   = A[0];
                w_res = {w_cf, A[WIDTH-1:1]};
            end
            4'd11: begin
                w_c   = A[WIDTH-1];
                w_res = {A[WIDTH-2:0], A[WIDTH-1]};
            end
            4'd12: begin
                w_c   = A[0];
                w_res = {A[0], A[WIDTH-1:1]};
            end
            4'd13: begin
                w_c   = A[0];
                w_res = {A[WIDTH-1], A[WIDTH-1:1]};
            end
            4'd14: begin
                w_res = B;
                w_mov = 1'b1;
            end
            default: w_we = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_live      <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_we        <= 1'b0;
            r_mov       <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept && !w_acc_mul) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_c         <= w_c;
                r_z         <= (w_res == '0);
                r_we        <= w_we;
                r_mov       <= w_mov;
            end else if (w_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_mul_res;
                r_c         <= w_mul_c;
                r_z         <= (w_mul_res == '0);
                r_we        <= 1'b1;
                r_mov       <= 1'b0;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (w_hs && !r_mov) begin
            r_flag_c <= r_c;
            r_flag_z <= r_z;
        end
    end

    assign OUT_VALID = r_out_valid;
    assign RESULT    = r_result;
    assign C         = r_c;
    assign Z         = r_z;
    assign RES_WE    = r_we;
    assign FLAG_C    = r_flag_c;
    assign FLAG_Z    = r_flag_z;

endmodule

// File: tb/tb_rat_alu_pipe.sv
// Scoreboard bench for rat_alu_pipe: random and directed ops against
// an arithmetic reference model of the ALU's architectural behaviour.
module tb_rat_alu_pipe;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         we;
        logic         mov;
    } exp_t;

    logic         CLK;
    logic         RST_N;
    logic         IN_VALID;
    logic         IN_READY;
    logic [3:0]   SEL;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] RESULT;
    logic         C;
    logic         Z;
    logic         RES_WE;
    logic         FLAG_C;
    logic         FLAG_Z;

    logic rnd_mode;
    logic force_rdy;
    logic rnd_rdy;

    exp_t q[$];
    int   n_tests;
    int   n_fail;
    bit   dcf;
    bit   dcz;
    bit   mf_c;
    bit   mf_z;

    assign OUT_READY = rnd_mode ? rnd_rdy : force_rdy;

    rat_alu_pipe #(.WIDTH(W)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .SEL(SEL),
        .A(A),
        .B(B),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .RESULT(RESULT),
        .C(C),
        .Z(Z),
        .RES_WE(RES_WE),
        .FLAG_C(FLAG_C),
        .FLAG_Z(FLAG_Z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input longint act,
                       input longint expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, expv, $time);
        end
    endtask

    // Reference model computed with plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] s,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input bit cf);
        exp_t   e;
        longint ua;
        longint ub;
        longint m;
        longint h;
        longint t;
        ua = longint'(a);
        ub = longint'(b);
        m  = longint'(1) << W;
        h  = m / 2;
        t  = 0;
        e  = '0;
        e.we = 1'b1;
        case (s)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                if (s == 4'd0) t = ua + ub;
                if (s == 4'd1) t = ua + ub + longint'(cf);
                if (s == 4'd2 || s == 4'd4) t = ua - ub;
                if (s == 4'd3) t = ua - ub - longint'(cf);
                e.c   = (t >= m) || (t < 0);
                e.res = W'((t + m) % m);
                e.we  = (s != 4'd4);
            end
            4'd5: e.res = a & b;
            4'd6: e.res = a | b;
            4'd7: e.res = a ^ b;
            4'd8: begin
                e.res = a & b;
                e.we  = 1'b0;
            end
            4'd9: begin
                t     = ua * 2 + longint'(cf);
                e.c   = (t >= m);
                e.res = W'(t % m);
            end
            4'd10: begin
                e.c   = (ua % 2) == 1;
                e.res = W'(ua / 2 + longint'(cf) * h);
            end
            4'd11: begin
                e.c   = (ua >= h);
                e.res = W'((ua * 2) % m + longint'(e.c));
            end
            4'd12: begin
                e.c   = (ua % 2) == 1;
                e.res = W'(ua / 2 + longint'(e.c) * h);
            end
            4'd13: begin
                e.c   = (ua % 2) == 1;
                e.res = W'(ua / 2 + ((ua >= h) ? h : 0));
            end
            4'd14: begin
                e.res = b;
                e.mov = 1'b1;
            end
            default: begin
`ifdef RAT_ALU_MUL_EN
                t     = ua * ub;
                e.c   = (t >= m);
                e.res = W'(t % m);
`else
                e.we  = 1'b0;
`endif
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic issue(input logic [3:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int waited);
        exp_t e;
        int   n;
        n = 0;
        IN_VALID = 1'b1;
        SEL = s;
        A = a;
        B = b;
        @(negedge CLK);
        while (!IN_READY && n < 200) begin
            n++;
            @(negedge CLK);
        end
        waited = n;
        if (n >= 200) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            e = model(s, a, b, dcf);
            q.push_back(e);
            if (!e.mov) begin
                dcf = e.c;
                dcz = e.z;
            end
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        exp_t e;
        mf_c = 1'b0;
        mf_z = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                q.delete();
                mf_c = 1'b0;
                mf_z = 1'b0;
            end else begin
                chk("flags", {FLAG_C, FLAG_Z}, {mf_c, mf_z});
                if (OUT_VALID) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = q[0];
                        chk("result", {RESULT, C, Z, RES_WE},
                            {e.res, e.c, e.z, e.we});
                        if (OUT_READY) begin
                            void'(q.pop_front());
                            if (!e.mov) begin
                                mf_c = e.c;
                                mf_z = e.z;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int   wt;
        int   n;
        logic [7:0] shifts [5];
        n_tests   = 0;
        n_fail    = 0;
        dcf       = 1'b0;
        dcz       = 1'b0;
        rnd_mode  = 1'b0;
        force_rdy = 1'b1;
        IN_VALID  = 1'b0;
        SEL       = '0;
        A         = '0;
        B         = '0;
        RST_N     = 1'b0;
        #3;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_regs", {RESULT, C, Z, RES_WE}, 0);
        chk("rst_flags", {FLAG_C, FLAG_Z}, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("in_ready_after_rst", IN_READY, 1);

        issue(4'd0, 8'hFF, 8'h01, wt);
        issue(4'd1, 8'h05, 8'h03, wt);
        issue(4'd2, 8'h03, 8'h05, wt);
        issue(4'd4, 8'h42, 8'h42, wt);
        issue(4'd14, 8'h33, 8'h00, wt);
        issue(4'd15, 8'h10, 8'h20, wt);

        shifts = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd13};
        foreach (shifts[i]) begin
            issue(4'd5, 8'h00, 8'h00, wt);
            issue(shifts[i][3:0], 8'h81, 8'h00, wt);
        end

        repeat (3) @(posedge CLK);
        #1;
        force_rdy = 1'b0;
        issue(4'd7, 8'h5A, 8'h0F, wt);
        IN_VALID = 1'b1;
        SEL = 4'd0;
        A = 8'h11;
        B = 8'h22;
        repeat (5) begin
            @(negedge CLK);
            chk("stall_in_ready", IN_READY, 0);
        end
        @(posedge CLK);
        #1;
        force_rdy = 1'b1;
        issue(4'd0, 8'h11, 8'h22, wt);
        chk("stall_release_wait", wt, 0);
        for (int i = 0; i < 4; i++) begin
            issue(4'($urandom_range(0, 14)), 8'($urandom),
                  8'($urandom), wt);
            chk("stream_wait", wt, 0);
        end

`ifdef RAT_ALU_MUL_EN
        repeat (2) @(posedge CLK);
        #1;
        issue(4'd15, 8'h10, 8'h20, wt);
        n = 1;
        while (n < 50) begin
            if (OUT_VALID) break;
            @(posedge CLK);
            #1;
            n++;
        end
        chk("mul_latency", n, W + 1);
        repeat (2) @(posedge CLK);
        #1;
        issue(4'd15, 8'h07, 8'h09, wt);
        repeat (3) @(posedge CLK);
`else
        repeat (2) @(posedge CLK);
        #1;
        force_rdy = 1'b0;
        issue(4'd0, 8'h12, 8'h34, wt);
        repeat (2) @(posedge CLK);
`endif
        #1;
        RST_N = 1'b0;
        #1;
        chk("midrst_out_valid", OUT_VALID, 0);
        chk("midrst_regs", {RESULT, C, Z, RES_WE}, 0);
        chk("midrst_flags", {FLAG_C, FLAG_Z}, 0);
        dcf = 1'b0;
        dcz = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        force_rdy = 1'b1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_in_ready", IN_READY, 1);

        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), 8'($urandom),
                  8'($urandom), wt);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge CLK);
                #1;
            end
        end

        rnd_mode = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge CLK);
            n++;
        end
        @(negedge CLK);
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
